// File: rtl/if_prefetch_unit.sv
// ---------------------------------------------------------------------------
// if_prefetch_unit
//
// Instruction-fetch stage for the pipelined MIPS datapath.  It owns the PC,
// issues at most one read per cycle to a synchronous instruction memory,
// buffers returned words (with the PC they were fetched from) in a small
// prefetch FIFO and hands them to ID over a valid/ready handshake.  Later
// stages can redirect the PC on a taken branch or jump, which flushes
// everything that was fetched down the wrong path.
//
// Parameters
//   ADDR_W    PC / address width in bits
//   DATA_W    instruction width in bits
//   DEPTH     prefetch FIFO entries (power of two, >= 2)
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   imem_req     read request to instruction memory this cycle
//   imem_addr    read address (the current PC)
//   imem_rdata   read data, valid exactly one cycle after imem_req
//   redirect     taken branch/jump: flush and restart from redirect_pc
//   redirect_pc  redirect target; low two bits are forced to zero
//   id_ready     ID accepts the head instruction this cycle
//   instr_valid  FIFO head holds a valid instruction
//   instr        head instruction (0 when not valid)
//   instr_pc     PC of the head instruction (0 when not valid)
//   instr_pc4    instr_pc + 4, wrapping (0 when not valid)
//   fifo_count   number of occupied FIFO entries
//
// Optional feature, enabled by defining the macro IF_STATS_EN:
//   stat_fetched  number of words pushed into the FIFO
//   stat_stall    cycles with instr_valid && !id_ready
//   stat_flush    number of redirects
//   All three clear on reset and wrap at 2^32.
// ---------------------------------------------------------------------------
module if_prefetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [DATA_W-1:0]        imem_rdata,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    input  logic                     id_ready,
    output logic                     instr_valid,
    output logic [DATA_W-1:0]        instr,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic [ADDR_W-1:0]        instr_pc4,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef IF_STATS_EN
    ,
    output logic [31:0]              stat_fetched,
    output logic [31:0]              stat_stall,
    output logic [31:0]              stat_flush
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic              issue;
    logic              push;
    logic              pop;
    logic [CW:0]       occupancy;
    logic              redirect_lsb_unused;

    // Redirect targets are always word aligned, so the low two bits of
    // redirect_pc carry no information.
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // Credit check: a request may only be issued if the FIFO has room for
    // every word already buffered plus the one still coming back from memory.
    // A pop in the same cycle is deliberately not counted as free space.
    // A redirect kills the returning word and any pop in the same cycle.
    always_comb begin
        occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
        issue     = !reset && !redirect && (occupancy < (CW+1)'(DEPTH));
        push      = inflight && !redirect;
        pop       = instr_valid && id_ready && !redirect;
    end

    assign imem_req    = issue;
    assign imem_addr   = pc;
    assign fifo_count  = count;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? data_mem[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr] : '0;
    assign instr_pc4   = instr_valid ? (pc_mem[rd_ptr] + ADDR_W'(4)) : '0;

    // PC, in-flight tracking and FIFO bookkeeping.  Reset wins over a
    // redirect, and a redirect empties the FIFO and drops the word that is
    // returning from memory this cycle.  req_pc remembers the address of
    // last cycle's request so the returning word can be tagged with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            pc       <= {redirect_pc[ADDR_W-1:2], 2'b00};
            req_pc   <= pc;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                pc <= pc + ADDR_W'(4);
            end
            req_pc   <= pc;
            inflight <= issue;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: the returning word is written together with the PC it
    // was fetched from.  The storage itself needs no reset because count
    // gates every read.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            data_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= req_pc;
        end
    end

`ifdef IF_STATS_EN
    // Performance counters, free-running and wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched <= '0;
            stat_stall   <= '0;
            stat_flush   <= '0;
        end else begin
            if (push) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (instr_valid && !id_ready) begin
                stat_stall <= stat_stall + 32'd1;
            end
            if (redirect) begin
                stat_flush <= stat_flush + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch_unit
//
// Directed bench for if_prefetch_unit with default parameters.  The memory
// model returns addr>>2 one cycle after each request, so every instruction
// must equal its own PC shifted right by two.  A per-cycle vector table
// covers reset, streaming, back-pressure and a redirect; hand-written
// sequences cover PC wrap-around and a reset pulse with a word in flight.
// ---------------------------------------------------------------------------
module tb_if_prefetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic [2:0]  fifo_count;
`ifdef IF_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_stall;
    logic [31:0] stat_flush;
`endif

    int checks = 0;
    int errors = 0;

    if_prefetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_pc4   (instr_pc4),
        .fifo_count  (fifo_count)
`ifdef IF_STATS_EN
        ,
        .stat_fetched(stat_fetched),
        .stat_stall  (stat_stall),
        .stat_flush  (stat_flush)
`endif
    );

    // 10 time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous instruction memory: word at addr is addr>>2
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr >> 2;
        else          imem_rdata <= 32'hDEAD_BEEF;
    end

    typedef struct {
        logic        rst;
        logic        rdr;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [2:0]  count;
    } vector_t;

    vector_t vec [25];

    // Inputs change at the falling edge and settle before being checked
    task automatic applyStimulus(input logic r, input logic rd,
                                 input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        reset       = r;
        redirect    = rd;
        redirect_pc = rpc;
        id_ready    = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic e_req,
                               input logic [31:0] e_addr, input logic e_valid,
                               input logic [31:0] e_pc, input logic [2:0] e_count);
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic [31:0] e_pc4;
        e_instr = e_valid ? (e_pc >> 2) : 32'h0;
        e_ipc   = e_valid ? e_pc : 32'h0;
        e_pc4   = e_valid ? (e_pc + 32'd4) : 32'h0;
        checks++;
        if (imem_req !== e_req || imem_addr !== e_addr || instr_valid !== e_valid ||
            instr !== e_instr || instr_pc !== e_ipc || instr_pc4 !== e_pc4 ||
            fifo_count !== e_count) begin
            errors++;
            $display("[TB] FAIL %s: got req=%0b addr=%h valid=%0b instr=%h pc=%h pc4=%h count=%0d, want req=%0b addr=%h valid=%0b instr=%h pc=%h pc4=%h count=%0d",
                     name, imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc4,
                     fifo_count, e_req, e_addr, e_valid, e_instr, e_ipc, e_pc4, e_count);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] got,
                              input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    initial begin
        bit found;

        //            rst   rdr   rpc           rdy   req   addr          valid pc            count
        vec[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        3'd0};
        vec[1]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        3'd0};
        vec[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 32'h0,        3'd0};
        vec[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b0, 32'h0,        3'd0};
        vec[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        1'b1, 32'h0,        3'd1};
        vec[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        1'b1, 32'h4,        3'd1};
        vec[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h10,       1'b1, 32'h8,        3'd1};
        vec[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h14,       1'b1, 32'h8,        3'd2};
        vec[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h18,       1'b1, 32'h8,        3'd3};
        vec[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h18,       1'b1, 32'h8,        3'd4};
        vec[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h18,       1'b1, 32'h8,        3'd4};
        vec[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h18,       1'b1, 32'h8,        3'd4};
        vec[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h18,       1'b1, 32'hC,        3'd3};
        vec[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1C,       1'b1, 32'h10,       3'd2};
        vec[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h20,       1'b1, 32'h14,       3'd2};
        vec[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h24,       1'b1, 32'h18,       3'd2};
        vec[16] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h28,       1'b1, 32'h1C,       3'd2};
        vec[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h2C,       1'b1, 32'h20,       3'd2};
        vec[18] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h30,       1'b1, 32'h24,       3'd2};
        vec[19] = '{1'b0, 1'b1, 32'h103,      1'b1, 1'b0, 32'h34,       1'b1, 32'h24,       3'd3};
        vec[20] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      1'b0, 32'h0,        3'd0};
        vec[21] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      1'b0, 32'h0,        3'd0};
        vec[22] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h108,      1'b1, 32'h100,      3'd1};
        vec[23] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10C,      1'b1, 32'h104,      3'd1};
        vec[24] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h110,      1'b1, 32'h108,      3'd1};

        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b1;
        @(posedge clk);

        for (int i = 0; i < 25; i++) begin
            applyStimulus(vec[i].rst, vec[i].rdr, vec[i].rpc, vec[i].rdy);
            checkOutput($sformatf("vec%0d", i), vec[i].req, vec[i].addr,
                        vec[i].valid, vec[i].pc, vec[i].count);
        end

        // PC wrap at the top of the address space
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        checkOutput("wrap_redirect", 1'b0, 32'h114, 1'b1, 32'h10C, 3'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_issue_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 3'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_issue_zero", 1'b1, 32'h0, 1'b0, 32'h0, 3'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_head_top", 1'b1, 32'h4, 1'b1, 32'hFFFF_FFFC, 3'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_head_zero", 1'b1, 32'h8, 1'b1, 32'h0, 3'd1);

`ifdef IF_STATS_EN
        checkValue("stat_flush_count", stat_flush, 32'd2);
`endif

        // Stall until three words are buffered and a fourth is in flight
        // (count 3 with no request means the in-flight flag is set)
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            if (fifo_count == 3'd3 && !imem_req) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL near_full_wait: got count=%0d req=%0b, want count=3 req=0",
                     fifo_count, imem_req);
        end

        // Single-cycle reset pulse with a word in flight
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("post_reset", 1'b1, 32'h0, 1'b0, 32'h0, 3'd0);
`ifdef IF_STATS_EN
        checkValue("stat_fetched_reset", stat_fetched, 32'd0);
        checkValue("stat_stall_reset", stat_stall, 32'd0);
        checkValue("stat_flush_reset", stat_flush, 32'd0);
`endif
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("post_reset_inflight_dropped", 1'b1, 32'h4, 1'b0, 32'h0, 3'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("post_reset_first_instr", 1'b1, 32'h8, 1'b1, 32'h0, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
